// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : legv8_pkg
// Purpose  : Shared types and encodings for the LEGv8 multi-cycle sequencer:
//            sequencer states, opcode patterns, ALU function and PC-select
//            codes, and an opcode classifier used by the decoder.
// Revision : 1.0 - initial release
// ============================================================================
package legv8_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_MEM   = 2'd3
  } state_e;

  // Instruction classes after opcode matching
  typedef enum logic [3:0] {
    C_ILLEGAL = 4'd0,
    C_ADD     = 4'd1,
    C_SUB     = 4'd2,
    C_AND     = 4'd3,
    C_ORR     = 4'd4,
    C_ADDI    = 4'd5,
    C_SUBI    = 4'd6,
    C_MOVZ    = 4'd7,
    C_MOVK    = 4'd8,
    C_LDUR    = 4'd9,
    C_STUR    = 4'd10,
    C_B       = 4'd11,
    C_CBZ     = 4'd12
  } insn_e;

  // 11-bit opcodes, IR[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // 10-bit opcodes, IR[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  // 9-bit opcodes, IR[31:23]
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;
  localparam logic [8:0]  OP_MOVK = 9'b111100101;
  // 8-bit opcode, IR[31:24]
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  // 6-bit opcode, IR[31:26]
  localparam logic [5:0]  OP_B    = 6'b000101;

  // ALU function select
  localparam logic [4:0] FS_AND    = 5'b00000;
  localparam logic [4:0] FS_OR     = 5'b00100;
  localparam logic [4:0] FS_ADD    = 5'b01000;
  localparam logic [4:0] FS_SUB    = 5'b01001;
  localparam logic [4:0] FS_PASS_A = 5'b10000;
  localparam logic [4:0] FS_PASS_B = 5'b10100;

  // PC select
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b10;

  // Opcode fields of different lengths never alias, so match order is free
  function automatic insn_e insn_class(input logic [31:0] ir);
    insn_e c;
    c = C_ILLEGAL;
    if      (ir[31:21] == OP_ADD)  c = C_ADD;
    else if (ir[31:21] == OP_SUB)  c = C_SUB;
    else if (ir[31:21] == OP_AND)  c = C_AND;
    else if (ir[31:21] == OP_ORR)  c = C_ORR;
    else if (ir[31:21] == OP_LDUR) c = C_LDUR;
    else if (ir[31:21] == OP_STUR) c = C_STUR;
    else if (ir[31:22] == OP_ADDI) c = C_ADDI;
    else if (ir[31:22] == OP_SUBI) c = C_SUBI;
    else if (ir[31:23] == OP_MOVZ) c = C_MOVZ;
    else if (ir[31:23] == OP_MOVK) c = C_MOVK;
    else if (ir[31:24] == OP_CBZ)  c = C_CBZ;
    else if (ir[31:26] == OP_B)    c = C_B;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_decode.sv
`default_nettype none
// ============================================================================
// Module   : legv8_decode
// Purpose  : Combinational control-word decode from the instruction register
//            and the current sequencer state.
// Revision : 1.0 - initial release
// ============================================================================
module legv8_decode
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       ir,
  input  state_e            state,
  input  logic              instr_valid,
  input  logic              mem_ready,
  input  logic              zero,
  output insn_e             cls,
  output logic              ir_load,
  output logic [4:0]        da,
  output logic [4:0]        sa,
  output logic [4:0]        sb,
  output logic [4:0]        fs,
  output logic [1:0]        ps,
  output logic [DATA_W-1:0] k,
  output logic              b_sel,
  output logic              reg_write,
  output logic              mem_write,
  output logic              mem_read,
  output logic              illegal
);

  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [4:0]        rm;
  logic [5:0]        shamt;
  logic [DATA_W-1:0] k_alu_imm;
  logic [DATA_W-1:0] k_wide;
  logic [DATA_W-1:0] k_keep_mask;
  logic [DATA_W-1:0] k_mem_off;
  logic [DATA_W-1:0] k_br;
  logic [DATA_W-1:0] k_cbz;

  assign rd    = ir[4:0];
  assign rn    = ir[9:5];
  assign rm    = ir[20:16];
  assign cls   = insn_class(ir);
  // hw field selects a 16-bit lane: shift by hw*16
  assign shamt = {ir[22:21], 4'b0000};

  assign k_alu_imm   = {{(DATA_W-12){1'b0}}, ir[21:10]};
  assign k_wide      = {{(DATA_W-16){1'b0}}, ir[20:5]} << shamt;
  assign k_keep_mask = ~({{(DATA_W-16){1'b0}}, 16'hFFFF} << shamt);
  assign k_mem_off   = {{(DATA_W-9){ir[20]}}, ir[20:12]};
  assign k_br        = {{(DATA_W-26){ir[25]}}, ir[25:0]};
  assign k_cbz       = {{(DATA_W-19){ir[23]}}, ir[23:5]};

  // Control word for the current state; everything defaults to inactive
  always_comb begin
    ir_load   = 1'b0;
    da        = '0;
    sa        = '0;
    sb        = '0;
    fs        = FS_AND;
    ps        = PS_HOLD;
    k         = '0;
    b_sel     = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    illegal   = 1'b0;
    unique case (state)
      ST_FETCH: ir_load = instr_valid;
      ST_EXEC: begin
        unique case (cls)
          C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI: begin
            sa        = rn;
            da        = rd;
            reg_write = 1'b1;
            ps        = PS_INC;
            if (cls == C_ADDI || cls == C_SUBI) begin
              b_sel = 1'b1;
              k     = k_alu_imm;
            end else begin
              sb = rm;
            end
            unique case (cls)
              C_ADD, C_ADDI: fs = FS_ADD;
              C_SUB, C_SUBI: fs = FS_SUB;
              C_ORR:         fs = FS_OR;
              default:       fs = FS_AND;
            endcase
          end
          C_MOVZ: begin
            k         = k_wide;
            fs        = FS_PASS_B;
            b_sel     = 1'b1;
            da        = rd;
            reg_write = 1'b1;
            ps        = PS_INC;
          end
          C_MOVK: begin
            // First pass clears the target lane, second pass ORs it in
            k         = k_keep_mask;
            sa        = rd;
            fs        = FS_AND;
            b_sel     = 1'b1;
            da        = rd;
            reg_write = 1'b1;
          end
          C_LDUR, C_STUR: begin
            sa    = rn;
            k     = k_mem_off;
            fs    = FS_ADD;
            b_sel = 1'b1;
          end
          C_B: begin
            k  = k_br;
            ps = PS_REL;
          end
          C_CBZ: begin
            sa = rd;
            fs = FS_PASS_A;
            k  = k_cbz;
            ps = zero ? PS_REL : PS_INC;
          end
          default: begin
            illegal = 1'b1;
            ps      = PS_INC;
          end
        endcase
      end
      ST_EXEC2: begin
        k         = k_wide;
        sa        = rd;
        fs        = FS_OR;
        b_sel     = 1'b1;
        da        = rd;
        reg_write = 1'b1;
        ps        = PS_INC;
      end
      ST_MEM: begin
        // Address path stays driven for the whole access
        sa    = rn;
        k     = k_mem_off;
        fs    = FS_ADD;
        b_sel = 1'b1;
        if (cls == C_STUR) begin
          sb        = rd;
          mem_write = 1'b1;
        end else begin
          mem_read = 1'b1;
        end
        if (mem_ready) begin
          ps = PS_INC;
          if (cls == C_LDUR) begin
            reg_write = 1'b1;
            da        = rd;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/legv8_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : legv8_sequencer
// Purpose  : Multi-cycle LEGv8 control sequencer. Holds the instruction
//            register and the FETCH/EXEC/EXEC2/MEM state; the control word is
//            decoded combinationally by legv8_decode.
// Revision : 1.0 - initial release
// ============================================================================
module legv8_sequencer
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              mem_ready,
  input  logic              zero,
  output logic              ir_load,
  output logic [4:0]        DA,
  output logic [4:0]        SA,
  output logic [4:0]        SB,
  output logic [4:0]        FS,
  output logic [1:0]        PS,
  output logic [DATA_W-1:0] k,
  output logic              B_sel,
  output logic              regWrite,
  output logic              memWrite,
  output logic              memRead,
  output logic              PC_sel,
  output logic              status_load,
  output logic              illegal,
  output logic              busy
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] ir_q;
  logic [31:0] ir_d;
  insn_e       cls;

  legv8_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .ir          (ir_q),
    .state       (state_q),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .zero        (zero),
    .cls         (cls),
    .ir_load     (ir_load),
    .da          (DA),
    .sa          (SA),
    .sb          (SB),
    .fs          (FS),
    .ps          (PS),
    .k           (k),
    .b_sel       (B_sel),
    .reg_write   (regWrite),
    .mem_write   (memWrite),
    .mem_read    (memRead),
    .illegal     (illegal)
  );

  assign PC_sel      = 1'b0;
  assign status_load = 1'b0;
  assign busy        = (state_q != ST_FETCH);

  // Next state and IR capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls == C_MOVK)                         state_d = ST_EXEC2;
        else if (cls == C_LDUR || cls == C_STUR)   state_d = ST_MEM;
        else                                       state_d = ST_FETCH;
      end
      ST_EXEC2: state_d = ST_FETCH;
      ST_MEM:   if (mem_ready) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  // State and IR registers; reset aborts any access immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_legv8_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_legv8_sequencer
// Purpose  : Self-checking bench for legv8_sequencer. Each instruction is
//            expanded by a transaction-level model into its expected per-cycle
//            control words; one compare process checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_legv8_sequencer;

  localparam int DATA_W = 64;

  localparam int K_ILL = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_ORR = 4,
                 K_ADDI = 5, K_SUBI = 6, K_MOVZ = 7, K_MOVK = 8,
                 K_LDUR = 9, K_STUR = 10, K_B = 11, K_CBZ = 12;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              mem_ready;
  logic              zero;
  logic              ir_load;
  logic [4:0]        DA, SA, SB, FS;
  logic [1:0]        PS;
  logic [DATA_W-1:0] k;
  logic              B_sel, regWrite, memWrite, memRead, PC_sel;
  logic              status_load, illegal, busy;

  legv8_sequencer #(.DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .zero        (zero),
    .ir_load     (ir_load),
    .DA          (DA),
    .SA          (SA),
    .SB          (SB),
    .FS          (FS),
    .PS          (PS),
    .k           (k),
    .B_sel       (B_sel),
    .regWrite    (regWrite),
    .memWrite    (memWrite),
    .memRead     (memRead),
    .PC_sel      (PC_sel),
    .status_load (status_load),
    .illegal     (illegal),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        ir_load;
    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  fs;
    logic [1:0]  ps;
    logic [63:0] k;
    logic        b_sel;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        pc_sel;
    logic        status_load;
    logic        illegal;
    logic        busy;
  } ctl_t;

  typedef struct {
    logic [31:0] instr;
    logic        iv;
    logic        mr;
    logic        z;
    ctl_t        exp;
  } cyc_t;

  ctl_t act;
  assign act = {ir_load, DA, SA, SB, FS, PS, k, B_sel, regWrite, memWrite,
                memRead, PC_sel, status_load, illegal, busy};

  cyc_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;
  logic chk_en   = 1'b0;
  ctl_t exp_cur;

  // Single compare point: every driven cycle, away from the rising edge
  always @(negedge clock) begin
    if (chk_en) begin
      n_assert++;
      if (act !== exp_cur) begin
        n_fail++;
        $display("FAIL ctl cycle %0d: got %h expected %h", cyc_no, act, exp_cur);
      end
    end
  end

  task automatic pin(input string name, input logic [95:0] got, input logic [95:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] m;
    m = ~64'd0 << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction

  function automatic int kind_of(input logic [31:0] w);
    if (w[31:21] == 11'b10001011000) return K_ADD;
    if (w[31:21] == 11'b11001011000) return K_SUB;
    if (w[31:21] == 11'b10001010000) return K_AND;
    if (w[31:21] == 11'b10101010000) return K_ORR;
    if (w[31:21] == 11'b11111000010) return K_LDUR;
    if (w[31:21] == 11'b11111000000) return K_STUR;
    if (w[31:22] == 10'b1001000100)  return K_ADDI;
    if (w[31:22] == 10'b1101000100)  return K_SUBI;
    if (w[31:23] == 9'b110100101)    return K_MOVZ;
    if (w[31:23] == 9'b111100101)    return K_MOVK;
    if (w[31:24] == 8'b10110100)     return K_CBZ;
    if (w[31:26] == 6'b000101)       return K_B;
    return K_ILL;
  endfunction

  function automatic void push(input logic [31:0] w, input logic iv, input logic mr,
                               input logic z, input ctl_t e);
    cyc_t c;
    c.instr = w; c.iv = iv; c.mr = mr; c.z = z; c.exp = e;
    q.push_back(c);
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) push($urandom, 1'b0, rb(), rb(), '0);
  endfunction

  // Expand one instruction into its whole expected cycle sequence
  function automatic void add_insn(input logic [31:0] w, input int nwait,
                                   input int zforce, output int idx);
    ctl_t        e;
    int          kd;
    logic        z;
    int          lane;
    logic [63:0] wide;
    kd   = kind_of(w);
    lane = 16 * int'(w[22:21]);
    wide = 64'(w[20:5]) << lane;
    idx  = q.size();
    e = '0; e.ir_load = 1'b1;
    push(w, 1'b1, rb(), rb(), e);
    z = (zforce < 0) ? rb() : 1'(zforce);
    e = '0; e.busy = 1'b1;
    case (kd)
      K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI: begin
        e.sa = w[9:5]; e.da = w[4:0]; e.reg_write = 1'b1; e.ps = 2'b01;
        if (kd == K_ADDI || kd == K_SUBI) begin
          e.b_sel = 1'b1; e.k = 64'(w[21:10]);
        end else e.sb = w[20:16];
        if (kd == K_ADD || kd == K_ADDI)      e.fs = 5'b01000;
        else if (kd == K_SUB || kd == K_SUBI) e.fs = 5'b01001;
        else if (kd == K_ORR)                 e.fs = 5'b00100;
        else                                  e.fs = 5'b00000;
      end
      K_MOVZ: begin
        e.k = wide; e.fs = 5'b10100; e.b_sel = 1'b1; e.da = w[4:0];
        e.reg_write = 1'b1; e.ps = 2'b01;
      end
      K_MOVK: begin
        e.k = ~(64'hFFFF << lane); e.sa = w[4:0]; e.fs = 5'b00000;
        e.b_sel = 1'b1; e.da = w[4:0]; e.reg_write = 1'b1;
      end
      K_LDUR, K_STUR: begin
        e.sa = w[9:5]; e.k = sx(64'(w[20:12]), 9); e.fs = 5'b01000; e.b_sel = 1'b1;
      end
      K_B:   begin e.k = sx(64'(w[25:0]), 26); e.ps = 2'b10; end
      K_CBZ: begin
        e.sa = w[4:0]; e.fs = 5'b10000; e.k = sx(64'(w[23:5]), 19);
        e.ps = z ? 2'b10 : 2'b01;
      end
      default: begin e.illegal = 1'b1; e.ps = 2'b01; end
    endcase
    push($urandom, rb(), rb(), z, e);
    if (kd == K_MOVK) begin
      e = '0; e.busy = 1'b1; e.k = wide; e.sa = w[4:0]; e.fs = 5'b00100;
      e.b_sel = 1'b1; e.da = w[4:0]; e.reg_write = 1'b1; e.ps = 2'b01;
      push($urandom, rb(), rb(), rb(), e);
    end
    if (kd == K_LDUR || kd == K_STUR) begin
      for (int i = 0; i <= nwait; i++) begin
        e = '0; e.busy = 1'b1; e.sa = w[9:5]; e.k = sx(64'(w[20:12]), 9);
        e.fs = 5'b01000; e.b_sel = 1'b1;
        if (kd == K_STUR) begin e.sb = w[4:0]; e.mem_write = 1'b1; end
        else e.mem_read = 1'b1;
        if (i == nwait) begin
          e.ps = 2'b01;
          if (kd == K_LDUR) begin e.reg_write = 1'b1; e.da = w[4:0]; end
        end
        push($urandom, rb(), (i == nwait), rb(), e);
      end
    end
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0]  r;
    int unsigned  c;
    r = $urandom;
    c = $urandom_range(0, 13);
    case (c)
      0:  return {11'b10001011000, r[20:0]};
      1:  return {11'b11001011000, r[20:0]};
      2:  return {11'b10001010000, r[20:0]};
      3:  return {11'b10101010000, r[20:0]};
      4:  return {10'b1001000100, r[21:0]};
      5:  return {10'b1101000100, r[21:0]};
      6:  return {9'b110100101, r[22:0]};
      7:  return {9'b111100101, r[22:0]};
      8:  return {11'b11111000010, r[20:0]};
      9:  return {11'b11111000000, r[20:0]};
      10: return {6'b000101, r[25:0]};
      11: return {8'b10110100, r[23:0]};
      12: return 32'h0;
      default: return r;
    endcase
  endfunction

  task automatic run_q(input int limit);
    cyc_t c;
    int   n;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      c = q.pop_front();
      @(posedge clock); #1;
      instr = c.instr; instr_valid = c.iv; mem_ready = c.mr; zero = c.z;
      exp_cur = c.exp; chk_en = 1'b1; cyc_no++;
      n++;
    end
    @(negedge clock); #1;
    chk_en = 1'b0; instr_valid = 1'b0;
  endtask

  initial begin
    int i_movz, i_movk, i_stur, i_cbz1, i_cbz0, i_ill, dummy, wr_cnt, ps_cnt;
    instr = '0; instr_valid = 1'b0; mem_ready = 1'b0; zero = 1'b0; reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    pin("reset_outputs", 96'(act), 96'd0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Directed sequence from the test plan
    add_idle(2);
    add_insn(32'hD2BFFFE0, 0, -1, i_movz);
    add_insn(32'hF2DFFFE1, 0, -1, i_movk);
    add_insn({11'b11111000000, 9'h004, 2'b00, 5'd3, 5'd7}, 3, -1, i_stur);
    add_insn({8'b10110100, 19'h7FFFE, 5'd4}, 0, 1, i_cbz1);
    add_insn({8'b10110100, 19'h7FFFE, 5'd4}, 0, 0, i_cbz0);
    add_insn(32'h00000000, 0, -1, i_ill);

    // Hand-computed values pin the model
    pin("movz_k",      96'(q[i_movz+1].exp.k), 96'h00000000FFFF0000);
    pin("movz_ps",     96'(q[i_movz+1].exp.ps), 96'd1);
    pin("movk1_k",     96'(q[i_movk+1].exp.k), 96'hFFFF0000FFFFFFFF);
    pin("movk1_ps",    96'(q[i_movk+1].exp.ps), 96'd0);
    pin("movk2_k",     96'(q[i_movk+2].exp.k), 96'h0000FFFF00000000);
    pin("movk2_fs",    96'(q[i_movk+2].exp.fs), 96'b00100);
    wr_cnt = 0; ps_cnt = 0;
    for (int j = i_stur; j < i_cbz1; j++) begin
      if (q[j].exp.mem_write) wr_cnt++;
      if (q[j].exp.ps != 2'b00) ps_cnt++;
      if (q[j].exp.reg_write) wr_cnt += 100;
    end
    pin("stur_memwrite_cycles", 96'(wr_cnt), 96'd4);
    pin("stur_ps_cycles",       96'(ps_cnt), 96'd1);
    pin("cbz_taken_k",  96'(q[i_cbz1+1].exp.k), 96'hFFFFFFFFFFFFFFFE);
    pin("cbz_taken_ps", 96'(q[i_cbz1+1].exp.ps), 96'd2);
    pin("cbz_not_ps",   96'(q[i_cbz0+1].exp.ps), 96'd1);
    pin("illegal_flag", 96'(q[i_ill+1].exp.illegal), 96'd1);
    run_q(q.size());

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      add_idle($urandom_range(0, 2));
      add_insn(gen(), $urandom_range(0, 4), -1, dummy);
    end
    run_q(q.size());

    // Reset asserted in the middle of an LDUR memory wait
    add_insn({11'b11111000010, 9'h1F0, 2'b00, 5'd2, 5'd9}, 8, -1, dummy);
    run_q(4);
    q.delete();
    pin("ldur_memread_before_reset", 96'(memRead), 96'd1);
    #1 reset_n = 1'b0;
    #1;
    pin("ldur_memread_after_reset", 96'(memRead), 96'd0);
    pin("reset_busy", 96'(busy), 96'd0);
    pin("reset_all_outputs", 96'(act), 96'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    add_idle(3);
    add_insn(32'hD2BFFFE0, 0, -1, dummy);
    run_q(q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/legv8_sequencer.md
# legv8_sequencer

Multi-cycle control sequencer for the LEGv8 64-bit datapath. It fetches an instruction word into an internal instruction register, decodes it, and drives the control-word fields (register addresses, function select, PC select, constant, write enables) one state at a time. Two-state instructions (MOVK) and data-memory wait states are handled here. It sits between the instruction memory and the register file, ALU, data memory and program counter.

## Interface
Parameters:
- `DATA_W`, 64, datapath width and width of `k`.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `instr`  in  32  instruction word from instruction memory
- `instr_valid`  in  1  `instr` is valid this cycle
- `mem_ready`  in  1  data memory has completed the current access
- `zero`  in  1  ALU zero flag for the current cycle's operation
- `ir_load`  out  1  IR captures `instr` at this edge
- `DA`, `SA`, `SB`  out  5 each  destination and source register addresses
- `FS`  out  5  ALU function select
- `PS`  out  2  PC select: 00 hold, 01 PC+4, 10 PC+(k<<2), 11 unused
- `k`  out  DATA_W  constant operand
- `B_sel`  out  1  ALU B input: 1 selects `k`, 0 selects register B
- `regWrite`  out  1  register-file write enable
- `memWrite`, `memRead`  out  1 each  data-memory strobes
- `PC_sel`  out  1  1 routes ALU result to the PC-relative adder base (unused, held 0)
- `status_load`  out  1  reserved, held 0
- `illegal`  out  1  one-cycle pulse when an undecodable instruction is retired
- `busy`  out  1  high in every state except FETCH

## Operation
- States: FETCH, EXEC, EXEC2, MEM.
- In FETCH, all outputs are 0 except `ir_load = instr_valid`. On `instr_valid`, IR <= `instr` and the sequencer goes to EXEC. Otherwise it stays in FETCH.
- Decode is combinational from IR and the state. Field sources: Rd = IR[4:0], Rn = IR[9:5], Rm = IR[20:16].
- R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (EXEC):
  - SA=Rn, SB=Rm, DA=Rd, B_sel=0, regWrite=1, PS=01, then FETCH.
- ADDI 1001000100, SUBI 1101000100 (EXEC):
  - k = zero-extended IR[21:10], B_sel=1, otherwise as R-type.
- MOVZ 110100101 (EXEC):
  - shift = IR[22:21] × 16; k = IR[20:5] << shift.
  - FS=PASS_B, B_sel=1, DA=Rd, regWrite=1, PS=01, then FETCH.
- MOVK 111100101 is two states:
  - EXEC: k = ~(0xFFFF << shift), SA=Rd, FS=AND, B_sel=1, DA=Rd, regWrite=1, PS=00, then EXEC2.
  - EXEC2: k = IR[20:5] << shift, SA=Rd, FS=OR, B_sel=1, DA=Rd, regWrite=1, PS=01, then FETCH.
- LDUR 11111000010 / STUR 11111000000:
  - EXEC: SA=Rn, k = sign-extended IR[20:12], FS=ADD, B_sel=1, no writes, PS=00, then MEM.
  - MEM: address controls are held; SB=Rd for STUR; memRead (LDUR) or memWrite (STUR) is asserted while `mem_ready`=0, PS=00.
  - On the `mem_ready`=1 cycle: the strobe stays asserted, LDUR asserts regWrite with DA=Rd, PS=01, then FETCH.
- B 000101 (EXEC): k = sign-extended IR[25:0], PS=10, then FETCH.
- CBZ 10110100 (EXEC):
  - SA=Rd, FS=PASS_A, k = sign-extended IR[23:5].
  - PS=10 if `zero`, else 01; then FETCH.
- Any other opcode (EXEC): `illegal`=1, no writes, PS=01, then FETCH.

## Timing
- Reset: state=FETCH, IR=0, all outputs 0. Reset is asynchronous and aborts any state, including MEM, with strobes dropping immediately.
- Latency from `instr_valid` sample to retire:
  - 2 cycles: R-type, I-type, MOVZ, B, CBZ, illegal.
  - 3 cycles: MOVK.
  - 3 + N cycles: LDUR/STUR, where N is the number of `mem_ready`=0 cycles in MEM.
- Exactly one PS≠00 cycle per instruction.
- `instr_valid` is ignored outside FETCH.
- `mem_ready` is ignored outside MEM.
- Back-to-back instructions incur one FETCH cycle each.

## Structure
- Package `legv8_pkg`:
  - state enum.
  - opcode constants.
  - FS codes: AND=00000, OR=00100, ADD=01000, SUB=01001, PASS_A=10000, PASS_B=10100.
  - PS codes.
- Sub-module `legv8_decode`: combinational IR + state → control fields.
- The top level holds IR, the state register and the transitions.

## Test plan
- Reset with `reset_n` low, then release, `instr_valid`=0 → state FETCH, all outputs 0, `busy`=0.
- MOVZ 0xD2BFFFE0 (hw=01, imm 0xFFFF, Rd=0) → EXEC: k=0x00000000FFFF0000, DA=0, regWrite=1, PS=01.
- MOVK 0xF2DFFFE1 (hw=10, Rd=1):
  - EXEC: k=0xFFFF0000FFFFFFFF, FS=AND, PS=00.
  - EXEC2: k=0x0000FFFF00000000, FS=OR, PS=01.
- STUR with `mem_ready` low for 3 cycles → memWrite high for 4 MEM cycles, PS=01 only on the ready cycle, regWrite never asserted.
- CBZ imm19=−2:
  - `zero`=1 → PS=10, k=0xFFFFFFFFFFFFFFFE.
  - `zero`=0 → PS=01.
- Opcode 0x00000000 → `illegal` for one cycle, no writes. Then reset asserted mid-MEM of an LDUR → memRead drops asynchronously and the sequencer is in FETCH.
